// File: rtl/anu_dmem_bridge_if.sv
// Word-bus interface between the data-memory bridge and memory.
// master = bridge side, slave = memory side.
interface anu_dmem_bridge_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/anu_dmem_bridge.sv
// Data-memory bridge: core load/store port to valid/ready word bus, with lane steering,
// load extension, misalignment detection and bus timeout. Stalls the core per access.
module anu_dmem_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    stall,
  output logic [31:0]             rsp_rdata,
  output logic                    err,
  anu_dmem_bridge_if.master       bus
);

  typedef enum logic [1:0] {StIdle, StReq, StRdata, StDone} state_e;

  localparam bit             TmoEn   = (TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT - 32'd1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [29:0]        addr_q;
  logic               we_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               load_regs;

  logic               req_active;
  logic               misaligned;
  logic               tmo_hit;
  logic [3:0]         strb_new;
  logic [31:0]        wdata_new;
  logic [31:0]        shifted;
  logic [31:0]        ext_rdata;

  assign req_active = req_valid && (req_size != 2'b00);
  assign misaligned = ((req_size == 2'b10) && req_addr[0]) ||
                      ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
  assign tmo_hit    = TmoEn && (cnt_q == TmoLast);

  // Byte-lane steering of store data, computed from the live request and latched on IDLE exit.
  always_comb begin
    strb_new  = 4'b1111;
    wdata_new = req_wdata;
    case (req_size)
      2'b01: begin
        strb_new  = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'b10: begin
        strb_new  = 4'b0011 << req_addr[1:0];
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_we) begin
      strb_new  = 4'b0000;
      wdata_new = 32'h0;
    end
  end

  always_comb begin
    shifted   = bus.bus_rdata >> {off_q, 3'b000};
    ext_rdata = shifted;
    case (size_q)
      2'b01:   ext_rdata = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b10:   ext_rdata = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    load_regs = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_active) begin
          if (misaligned) begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d   = StReq;
            cnt_d     = '0;
            load_regs = 1'b1;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.bus_ready) begin
          if (we_q) begin
            state_d = StDone;
            rdata_d = 32'h0;
          end else if (bus.bus_rvalid) begin
            state_d = StDone;
            rdata_d = ext_rdata;
          end else begin
            state_d = StRdata;
            cnt_d   = '0;
          end
        end else if (tmo_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      StRdata: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.bus_rvalid) begin
          state_d = StDone;
          rdata_d = ext_rdata;
        end else if (tmo_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'h0;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (load_regs) begin
        addr_q   <= req_addr[31:2];
        we_q     <= req_we;
        wstrb_q  <= strb_new;
        wdata_q  <= wdata_new;
        off_q    <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
      end
    end
  end

  // Stall is gated by reset so a request held across reset does not freeze the core.
  assign stall = rst_n && ((state_q == StReq) || (state_q == StRdata) ||
                           ((state_q == StIdle) && req_active));

  assign rsp_rdata     = rdata_q;
  assign err           = err_q;
  assign bus.bus_valid = (state_q == StReq);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q, 2'b00};
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_anu_dmem_bridge.sv
// Directed bench for anu_dmem_bridge: stores, loads, misalignment, timeout, reset mid-access.
module tb_anu_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rsp_rdata;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  anu_dmem_bridge_if bus_if ();

  anu_dmem_bridge #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .bus        (bus_if)
  );

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
    #2;
    check_b("rst_stall", stall, 1'b0);
    check_b("rst_err", err, 1'b0);
    check_b("rst_valid", bus_if.bus_valid, 1'b0);
    check_b("rst_we", bus_if.bus_we, 1'b0);
    check_w("rst_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
    check_w("rst_wdata", bus_if.bus_wdata, 32'h0);
    check_w("rst_rdata", rsp_rdata, 32'h0);
    next_cycle(); rst_n = 1'b1; settle();
    check_b("idle_stall", stall, 1'b0);

    // sb to 0x103, bus ready immediately
    next_cycle();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h103; req_wdata = 32'hAB;
    bus_if.bus_ready = 1'b1;
    settle();
    check_b("sb_idle_stall", stall, 1'b1);
    check_b("sb_idle_valid", bus_if.bus_valid, 1'b0);
    next_cycle(); settle();
    check_b("sb_req_valid", bus_if.bus_valid, 1'b1);
    check_b("sb_req_we", bus_if.bus_we, 1'b1);
    check_b("sb_req_stall", stall, 1'b1);
    check_w("sb_addr", bus_if.bus_addr, 32'h100);
    check_w("sb_wstrb", 32'(bus_if.bus_wstrb), 32'h8);
    check_w("sb_wdata", bus_if.bus_wdata, 32'hABAB_ABAB);
    next_cycle(); settle();
    check_b("sb_done_stall", stall, 1'b0);
    check_b("sb_done_err", err, 1'b0);
    check_b("sb_done_valid", bus_if.bus_valid, 1'b0);

    // lh signed at 0x202, rdata arrives in the third RDATA cycle
    next_cycle();
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b1; req_addr = 32'h202;
    bus_if.bus_ready = 1'b1; bus_if.bus_rvalid = 1'b0;
    settle();
    check_b("lh_idle_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("lh_req_valid", bus_if.bus_valid, 1'b1);
    check_w("lh_addr", bus_if.bus_addr, 32'h200);
    check_w("lh_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
    check_b("lh_we", bus_if.bus_we, 1'b0);
    next_cycle(); bus_if.bus_ready = 1'b0; settle();
    check_b("lh_rd1_valid", bus_if.bus_valid, 1'b0);
    check_b("lh_rd1_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("lh_rd2_stall", stall, 1'b1);
    next_cycle(); bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h8001_1234; settle();
    check_b("lh_rd3_stall", stall, 1'b1);
    next_cycle(); bus_if.bus_rvalid = 1'b0; settle();
    check_w("lh_rdata", rsp_rdata, 32'hFFFF_8001);
    check_b("lh_done_stall", stall, 1'b0);
    check_b("lh_done_err", err, 1'b0);

    // lhu at 0x202, ready and rvalid together
    next_cycle();
    req_signed = 1'b0; bus_if.bus_ready = 1'b1; bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata = 32'h8001_1234;
    settle();
    check_b("lhu_idle_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("lhu_req_valid", bus_if.bus_valid, 1'b1);
    next_cycle(); settle();
    check_w("lhu_rdata", rsp_rdata, 32'h0000_8001);
    check_b("lhu_done_stall", stall, 1'b0);

    // misaligned lw at 0x6
    next_cycle();
    req_size = 2'b11; req_addr = 32'h6; bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0;
    settle();
    check_b("mis_idle_stall", stall, 1'b1);
    check_b("mis_idle_valid", bus_if.bus_valid, 1'b0);
    next_cycle(); settle();
    check_b("mis_done_err", err, 1'b1);
    check_b("mis_done_stall", stall, 1'b0);
    check_b("mis_done_valid", bus_if.bus_valid, 1'b0);
    check_w("mis_rdata", rsp_rdata, 32'h0);
    next_cycle(); req_valid = 1'b0; settle();
    check_b("mis_after_err", err, 1'b0);
    check_b("mis_after_stall", stall, 1'b0);

    // sw with bus_ready held low: times out after 4 REQ cycles
    next_cycle();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 32'h10;
    req_wdata = 32'hDEAD_BEEF;
    settle();
    check_b("tmo_idle_stall", stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      check_b($sformatf("tmo_req%0d_valid", i), bus_if.bus_valid, 1'b1);
      check_b($sformatf("tmo_req%0d_stall", i), stall, 1'b1);
    end
    check_w("tmo_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
    next_cycle(); settle();
    check_b("tmo_done_valid", bus_if.bus_valid, 1'b0);
    check_b("tmo_done_err", err, 1'b1);
    check_b("tmo_done_stall", stall, 1'b0);
    next_cycle(); req_valid = 1'b0; settle();
    check_b("tmo_idle_valid", bus_if.bus_valid, 1'b0);
    check_b("tmo_idle_err", err, 1'b0);
    check_b("tmo_idle_stall2", stall, 1'b0);

    // back-to-back sw then lb, ready and rvalid together
    next_cycle();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 32'h24;
    req_wdata = 32'h1122_3344;
    bus_if.bus_ready = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFE_BA5E;
    settle();
    check_b("b2b_sw_idle_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("b2b_sw_valid", bus_if.bus_valid, 1'b1);
    check_w("b2b_sw_addr", bus_if.bus_addr, 32'h24);
    check_w("b2b_sw_wstrb", 32'(bus_if.bus_wstrb), 32'hF);
    check_w("b2b_sw_wdata", bus_if.bus_wdata, 32'h1122_3344);
    next_cycle(); settle();
    check_b("b2b_sw_done_stall", stall, 1'b0);
    check_b("b2b_sw_done_err", err, 1'b0);
    next_cycle();
    req_we = 1'b0; req_size = 2'b01; req_signed = 1'b1; req_addr = 32'h25;
    settle();
    check_b("b2b_lb_idle_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("b2b_lb_valid", bus_if.bus_valid, 1'b1);
    check_w("b2b_lb_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
    check_w("b2b_lb_addr", bus_if.bus_addr, 32'h24);
    next_cycle(); settle();
    check_b("b2b_lb_done_stall", stall, 1'b0);
    check_w("b2b_lb_rdata", rsp_rdata, 32'hFFFF_FFBA);

    // reset asserted while in RDATA, then a fresh lw
    next_cycle();
    req_size = 2'b11; req_signed = 1'b0; req_addr = 32'h40;
    bus_if.bus_ready = 1'b1; bus_if.bus_rvalid = 1'b0;
    settle();
    check_b("rr_idle_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("rr_req_valid", bus_if.bus_valid, 1'b1);
    next_cycle(); bus_if.bus_ready = 1'b0; settle();
    check_b("rr_rdata_stall", stall, 1'b1);
    check_b("rr_rdata_valid", bus_if.bus_valid, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    settle();
    check_b("rr_rst_stall", stall, 1'b0);
    check_b("rr_rst_err", err, 1'b0);
    check_b("rr_rst_valid", bus_if.bus_valid, 1'b0);
    check_b("rr_rst_we", bus_if.bus_we, 1'b0);
    check_w("rr_rst_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
    check_w("rr_rst_wdata", bus_if.bus_wdata, 32'h0);
    check_w("rr_rst_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    bus_if.bus_ready = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h5A5A_A5A5;
    settle();
    check_b("rr_fresh_idle_stall", stall, 1'b1);
    next_cycle(); settle();
    check_b("rr_fresh_valid", bus_if.bus_valid, 1'b1);
    check_w("rr_fresh_addr", bus_if.bus_addr, 32'h40);
    next_cycle(); settle();
    check_w("rr_fresh_rdata", rsp_rdata, 32'h5A5A_A5A5);
    check_b("rr_fresh_done_stall", stall, 1'b0);
    check_b("rr_fresh_done_err", err, 1'b0);
    next_cycle(); req_valid = 1'b0; settle();
    check_b("rr_final_stall", stall, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
